mic_frame_writer: RTL

Downstream consumer of the per-mic decimation filter outputs. Captures one 16-bit sample per mic each time the filter output valid rises, and packs sample sets into ping-pong frame buffers in the Nios-shared on-chip RAM (second port). After each completed frame it posts a mailbox word and holds an IRQ until the Nios clears the mailbox. Replaces ad-hoc single-set write logic in the top level and runs in the sys_clk domain.

---
 rtl/mic_frame_pkg.sv | 37 +++
 rtl/mic_frame_writer_sync.sv | 31 +++
 rtl/mic_frame_writer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mic_frame_pkg.sv
// Shared types, mailbox layout and helpers for the mic frame writer.
package mic_frame_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    POST = 3'd2,
    RD   = 3'd3,
    CHK  = 3'd4
  } state_t;

  localparam int SAMPLE_W      = 16;
  localparam int MBX_VALID_BIT = 31;
  localparam int MBX_BUF_BIT   = 30;
  localparam int MBX_SEQ_LSB   = 0;
  localparam int MBX_SEQ_W     = 16;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Mailbox word: valid flag, buffer just completed, frame sequence number.
  function automatic logic [31:0] mbx_word(input logic buf_v, input logic [15:0] seq_v);
    logic [31:0] w;
    w                               = 32'd0;
    w[MBX_VALID_BIT]                = 1'b1;
    w[MBX_BUF_BIT]                  = buf_v;
    w[MBX_SEQ_LSB +: MBX_SEQ_W]     = seq_v;
    return w;
  endfunction

endpackage

// File: rtl/mic_frame_writer_sync.sv
// Brings the slow-domain valid strobe into clk and emits a one-cycle pulse on its rising edge.
module valid_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic pulse_r;

  // Two-flop synchroniser, one history flop and a registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r  <= 1'b0;
      sync_r  <= 1'b0;
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      meta_r  <= async_in;
      sync_r  <= meta_r;
      prev_r  <= sync_r;
      pulse_r <= sync_r & ~prev_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/mic_frame_writer.sv
// Packs per-mic sample sets into ping-pong frame buffers in shared RAM and
// posts a mailbox word plus level IRQ per completed frame.
module mic_frame_writer
  import mic_frame_pkg::*;
#(
  parameter int MIC_N         = 2,
  parameter int FRAME_LEN     = 64,
  parameter int ADDR_W        = 10,
  parameter int RD_LAT        = 2,
  parameter int POLL_INTERVAL = 256
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic                      enable,
  input  logic                      in_valid,
  input  logic [MIC_N*SAMPLE_W-1:0] in_data,
  output logic [ADDR_W-1:0]         avm_address,
  output logic                      avm_chipselect,
  output logic                      avm_write,
  output logic [31:0]               avm_writedata,
  output logic [3:0]                avm_byteenable,
  input  logic [31:0]               avm_readdata,
  output logic                      irq,
  output logic [15:0]               overrun_cnt,
  output logic [15:0]               drop_cnt
);

  localparam int WPS       = MIC_N / 2;
  localparam int BUF_WORDS = FRAME_LEN * WPS;
  localparam int SET_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int WORD_W    = (WPS > 1) ? $clog2(WPS) : 1;
  localparam int PT_W      = $clog2(POLL_INTERVAL + 1);
  localparam int RC_W      = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] MBX_ADDR = '1;

  state_t                      state_r, state_s;
  logic                        buf_r, buf_s;
  logic [SET_W-1:0]            set_r, set_s;
  logic [WORD_W-1:0]           word_r, word_s;
  logic [15:0]                 seq_r, seq_s;
  logic                        posted_r, posted_s;
  logic [PT_W-1:0]             poll_tmr_r, poll_tmr_s;
  logic [RC_W-1:0]             rd_cnt_r, rd_cnt_s;
  logic                        pend_r;
  logic [MIC_N*SAMPLE_W-1:0]   hold_r;
  logic                        pend_clr_s;
  logic                        ovr_inc_s;
  logic                        rd_start_s;
  logic                        edge_s;
  logic                        edge_acc_s;
  logic                        cs_s, we_s;
  logic [ADDR_W-1:0]           addr_s;
  logic [31:0]                 wdata_s;
  logic                        cs_r, we_r, irq_r;
  logic [ADDR_W-1:0]           addr_r;
  logic [31:0]                 wdata_r;
  logic [15:0]                 ovr_cnt_r, drop_cnt_r;

  valid_edge_sync u_sync (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .async_in (in_valid),
    .pulse    (edge_s)
  );

  assign edge_acc_s = edge_s & enable;

  // Next-state logic: sample writes take priority over mailbox polling at IDLE.
  always_comb begin
    state_s    = state_r;
    buf_s      = buf_r;
    set_s      = set_r;
    word_s     = word_r;
    seq_s      = seq_r;
    posted_s   = posted_r;
    poll_tmr_s = poll_tmr_r;
    rd_cnt_s   = rd_cnt_r;
    pend_clr_s = 1'b0;
    ovr_inc_s  = 1'b0;
    rd_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!enable) begin
          set_s  = '0;
          word_s = '0;
        end else begin
          set_s  = set_r;
        end
        if (pend_r) begin
          state_s = WR;
          word_s  = '0;
        end else if (posted_r && (poll_tmr_r == '0)) begin
          state_s    = RD;
          rd_cnt_s   = '0;
          rd_start_s = 1'b1;
        end else if (poll_tmr_r != '0) begin
          poll_tmr_s = poll_tmr_r - PT_W'(1);
        end else begin
          poll_tmr_s = poll_tmr_r;
        end
      end
      WR: begin
        if (word_r == WORD_W'(WPS - 1)) begin
          pend_clr_s = 1'b1;
          if (set_r == SET_W'(FRAME_LEN - 1)) begin
            state_s = POST;
            set_s   = '0;
          end else begin
            state_s = IDLE;
            set_s   = set_r + SET_W'(1);
          end
        end else begin
          word_s = word_r + WORD_W'(1);
        end
      end
      POST: begin
        if (!posted_r) begin
          posted_s = 1'b1;
        end else begin
          ovr_inc_s = 1'b1;
        end
        buf_s   = ~buf_r;
        seq_s   = seq_r + 16'd1;
        state_s = IDLE;
      end
      RD: begin
        if (rd_cnt_r == RC_W'(RD_LAT - 1)) begin
          state_s = CHK;
        end else begin
          rd_cnt_s = rd_cnt_r + RC_W'(1);
        end
      end
      CHK: begin
        if (avm_readdata == 32'd0) begin
          posted_s = 1'b0;
        end else begin
          posted_s = posted_r;
        end
        poll_tmr_s = PT_W'(POLL_INTERVAL - 1);
        state_s    = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Bus outputs for the cycle spent in the next state, so they can be registered.
  always_comb begin
    cs_s    = 1'b0;
    we_s    = 1'b0;
    addr_s  = '0;
    wdata_s = 32'd0;
    case (state_s)
      WR: begin
        cs_s    = 1'b1;
        we_s    = 1'b1;
        addr_s  = ADDR_W'(int'(buf_s) * BUF_WORDS + int'(set_s) * WPS + int'(word_s));
        wdata_s = hold_r[int'(word_s) * (2 * SAMPLE_W) +: 32];
      end
      POST: begin
        if (!posted_s) begin
          cs_s    = 1'b1;
          we_s    = 1'b1;
          addr_s  = MBX_ADDR;
          wdata_s = mbx_word(buf_s, seq_s);
        end else begin
          cs_s    = 1'b0;
        end
      end
      RD: begin
        if (rd_start_s) begin
          cs_s   = 1'b1;
          addr_s = MBX_ADDR;
        end else begin
          cs_s   = 1'b0;
        end
      end
      default: begin
        cs_s = 1'b0;
      end
    endcase
  end

  // FSM and frame-position state registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r    <= IDLE;
      buf_r      <= 1'b0;
      set_r      <= '0;
      word_r     <= '0;
      seq_r      <= 16'd0;
      posted_r   <= 1'b0;
      poll_tmr_r <= '0;
      rd_cnt_r   <= '0;
    end else begin
      state_r    <= state_s;
      buf_r      <= buf_s;
      set_r      <= set_s;
      word_r     <= word_s;
      seq_r      <= seq_s;
      posted_r   <= posted_s;
      poll_tmr_r <= poll_tmr_s;
      rd_cnt_r   <= rd_cnt_s;
    end
  end

  // Holding register: a new edge is accepted when free or being freed this cycle, else dropped.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pend_r     <= 1'b0;
      hold_r     <= '0;
      drop_cnt_r <= 16'd0;
    end else if (edge_acc_s && (!pend_r || pend_clr_s)) begin
      pend_r     <= 1'b1;
      hold_r     <= in_data;
    end else if (edge_acc_s) begin
      drop_cnt_r <= sat_inc16(drop_cnt_r);
    end else if (pend_clr_s) begin
      pend_r     <= 1'b0;
    end else begin
      pend_r     <= pend_r;
    end
  end

  // Overrun counter: frames finished while the previous one is still unacknowledged.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ovr_cnt_r <= 16'd0;
    end else if (ovr_inc_s) begin
      ovr_cnt_r <= sat_inc16(ovr_cnt_r);
    end else begin
      ovr_cnt_r <= ovr_cnt_r;
    end
  end

  // Registered bus and interrupt outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cs_r    <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      irq_r   <= 1'b0;
    end else begin
      cs_r    <= cs_s;
      we_r    <= we_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      irq_r   <= posted_s;
    end
  end

  assign avm_address    = addr_r;
  assign avm_chipselect = cs_r;
  assign avm_write      = we_r;
  assign avm_writedata  = wdata_r;
  assign avm_byteenable = 4'hF;
  assign irq            = irq_r;
  assign overrun_cnt    = ovr_cnt_r;
  assign drop_cnt       = drop_cnt_r;

endmodule
